// File: rtl/tff_arb_pkg.sv
// Shared definitions for the toggle-flop arbiter.
//   state_t  : arbiter FSM states (IDLE, GRANT)
//   pick_t   : round-robin pick result {valid, idx}
//   rr_pick  : first set request bit scanning ptr, ptr+1, ... modulo n
package tff_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int MAX_REQ     = 16;
    localparam int IDX_W       = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // ptr < n and k < n, so ptr+k < 2n and a single subtract wraps it.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 n);
        pick_t          p;
        logic [IDX_W:0] cand;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n && !p.valid) begin
                cand = {1'b0, ptr} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(n))
                    cand = cand - (IDX_W+1)'(n);
                if (req[cand[IDX_W-1:0]]) begin
                    p.valid = 1'b1;
                    p.idx   = cand[IDX_W-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/tff_bank.sv
// Bank of WIDTH toggle flip-flops.
//   clk, reset_n : clock, async active-low reset (q -> 0)
//   clr          : synchronous clear, beats toggle_en
//   toggle_en    : per-bit toggle enable
//   q            : bank state
module tff_cell (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic t,
    output logic q
);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= 1'b0;
        else if (clr)  q <= 1'b0;
        else if (t)    q <= ~q;
    end
endmodule

module tff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] toggle_en,
    output logic [WIDTH-1:0] q
);
    for (genvar b = 0; b < WIDTH; b++) begin : g_cell
        tff_cell u_cell (
            .clk     (clk),
            .reset_n (reset_n),
            .clr     (clr),
            .t       (toggle_en[b]),
            .q       (q[b])
        );
    end
endmodule

// File: rtl/tff_toggle_arbiter.sv
// Round-robin arbiter sharing one toggle-flop bank among NUM_REQ requesters.
//   clk, reset_n : clock, async active-low reset
//   req          : per-requester request level
//   mask         : per-requester toggle mask, requester i at [i*WIDTH +: WIDTH]
//   clr          : synchronous bank clear, highest priority
//   gnt          : registered one-hot grant (one cycle)
//   busy         : high while in GRANT
//   done         : one-cycle pulse after the toggle edge
//   q            : bank state
module tff_toggle_arbiter
    import tff_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] mask,
    input  logic                     clr,
    output logic [NUM_REQ-1:0]       gnt,
    output logic                     busy,
    output logic                     done,
    output logic [WIDTH-1:0]         q
);

    state_t             state, state_d;
    logic [IDX_W-1:0]   ptr, ptr_d;
    logic [IDX_W-1:0]   winner, winner_d;
    logic [WIDTH-1:0]   mask_lat, mask_lat_d;
    logic [NUM_REQ-1:0] gnt_d;
    logic               done_d;
    logic [WIDTH-1:0]   toggle_en;
    pick_t              pick;

    assign pick = rr_pick(MAX_REQ'(req), ptr, NUM_REQ);
    assign busy = (state == GRANT);

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        winner_d   = winner;
        mask_lat_d = mask_lat;
        gnt_d      = '0;
        done_d     = 1'b0;
        toggle_en  = '0;
        case (state)
            IDLE: begin
                // clr in IDLE only clears the bank; arbitration waits a cycle.
                if (!clr && pick.valid) begin
                    state_d    = GRANT;
                    winner_d   = pick.idx;
                    mask_lat_d = mask[int'(pick.idx)*WIDTH +: WIDTH];
                    gnt_d      = NUM_REQ'(1) << pick.idx;
                end
            end
            GRANT: begin
                // Bank gives clr priority, so a clr here discards the toggle
                // while the rest of the handshake completes normally.
                toggle_en = mask_lat;
                done_d    = 1'b1;
                ptr_d     = (winner == IDX_W'(NUM_REQ-1)) ? '0 : winner + IDX_W'(1);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            winner   <= '0;
            mask_lat <= '0;
            gnt      <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            winner   <= winner_d;
            mask_lat <= mask_lat_d;
            gnt      <= gnt_d;
            done     <= done_d;
        end
    end

    tff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .toggle_en (toggle_en),
        .q         (q)
    );

endmodule
